// File: rtl/time_disp_pkg.sv
// time_disp_pkg: digit indices, segment constants and snapshot layout for the time display scanner.
package time_disp_pkg;
   localparam logic [2:0] DIG_SU = 3'd0;
   localparam logic [2:0] DIG_ST = 3'd1;
   localparam logic [2:0] DIG_MU = 3'd2;
   localparam logic [2:0] DIG_MT = 3'd3;
   localparam logic [2:0] DIG_HU = 3'd4;
   localparam logic [2:0] DIG_HT = 3'd5;
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH = 7'h40;
   // active-high {g..a}, entry 0 is the rightmost
   localparam logic [9:0][6:0] SEG_TABLE = {7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
                                            7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
   typedef struct packed {
      logic [1:0] ht;
      logic [3:0] hu;
      logic [3:0] mt;
      logic [3:0] mu;
      logic [3:0] st;
      logic [3:0] su;
   } time_t;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: BCD digit to active-high {g..a} segments, dash for values above 9.
module bcd_to_7seg
   import time_disp_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);
   assign o_seg = i_bcd > 4'd9 ? SEG_DASH : SEG_TABLE[i_bcd];
endmodule

// File: rtl/time_display_scanner.sv
// time_display_scanner: multiplexes a frame-consistent snapshot of HH.MM.SS onto six
// active-low common-anode digits, blanking the first cycle of every slot to avoid ghosting.
module time_display_scanner
   import time_disp_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sec_units,
   input  logic [3:0] sec_tens,
   input  logic [3:0] min_units,
   input  logic [3:0] min_tens,
   input  logic [3:0] hour_units,
   input  logic [1:0] hour_tens,
   input  logic       show_sec,
   output logic [5:0] an_n,
   output logic [6:0] seg_n,
   output logic       dp_n
);
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

   logic [PW-1:0] r_p;
   logic [2:0]    r_idx;
   time_t         r_snap;
   logic          r_first;
   logic [5:0]    r_an_n;
   logic [6:0]    r_seg_n;
   logic          r_dp_n;

   time_t      w_in;
   logic       w_wrap;
   logic       w_en;
   logic       w_dp;
   logic [3:0] w_digit;
   logic [6:0] w_bcd_seg;
   logic [6:0] w_seg;

   bcd_to_7seg u_dec (
      .i_bcd (w_digit),
      .o_seg (w_bcd_seg)
   );

   always_comb begin
      w_in    = {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
      w_wrap  = r_p == P_LAST;
      w_digit = r_idx == DIG_SU ? r_snap.su :
                r_idx == DIG_ST ? r_snap.st :
                r_idx == DIG_MU ? r_snap.mu :
                r_idx == DIG_MT ? r_snap.mt :
                r_idx == DIG_HU ? r_snap.hu : {2'b00, r_snap.ht};
      // hour tens of 2 or 3 is illegal on a 12-hour clock, shown as a dash
      w_seg   = (r_idx == DIG_HT && r_snap.ht[1]) ? SEG_DASH : w_bcd_seg;
      w_en    = r_p != '0
                && !(r_idx == DIG_HT && r_snap.ht == 2'd0)
                && !(!show_sec && (r_idx == DIG_SU || r_idx == DIG_ST));
      w_dp    = (r_idx == DIG_HU || (r_idx == DIG_MU && show_sec)) && !r_snap.su[0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_p     <= '0;
         r_idx   <= '0;
         r_snap  <= '0;
         r_first <= 1'b1;
         r_an_n  <= 6'h3F;
         r_seg_n <= ~SEG_BLANK;
         r_dp_n  <= 1'b1;
      end else begin
         r_p     <= w_wrap ? '0 : r_p + 1'b1;
         r_first <= 1'b0;
         if (w_wrap)
            r_idx <= r_idx == DIG_HT ? DIG_SU : r_idx + 3'd1;
         if (r_first || (w_wrap && r_idx == DIG_HT))
            r_snap <= w_in;
         r_an_n  <= w_en ? ~(6'd1 << r_idx) : 6'h3F;
         r_seg_n <= w_en ? ~w_seg : ~SEG_BLANK;
         r_dp_n  <= !(w_en && w_dp);
      end
   end

   assign an_n  = r_an_n;
   assign seg_n = r_seg_n;
   assign dp_n  = r_dp_n;
endmodule
